// File: rtl/mips_mem_responder.sv
// Unified instruction/data memory for the multicycle MIPS datapath: accepts one
// fetch/load/store in IDLE, waits WAIT_CYCLES, then completes with a memready pulse.
module mips_mem_responder #(
   parameter int          ADDR_BITS   = 8,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 memread,
   input  logic                 memwrite,
   input  logic [31:0]          address,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   output logic                 memready,
   output logic                 err,
   output logic                 busy,
   input  logic                 ld_en,
   input  logic [ADDR_BITS-1:0] ld_addr,
   input  logic [31:0]          ld_data,
   output logic [1:0]           dbg_state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] idx_q;
   logic [31:0]          wdata_q;
   logic                 rd_q, wr_q, rej_q;
   logic [31:0]          readdata_q;
   logic                 memready_q, err_q;
   logic [31:0]          mem_q [2**ADDR_BITS];

   logic                 req_live, rej_live, accept, go_resp;
   logic [ADDR_BITS-1:0] acc_idx;
   logic [31:0]          acc_wdata, rd_val;
   logic                 acc_rd, acc_wr, acc_rej;

   assign req_live = memread | memwrite;
   assign rej_live = (address[1:0] != 2'b00) ||
                     ((address >> (ADDR_BITS + 2)) != 32'd0) ||
                     (memread && memwrite);
   assign accept   = (state_q == S_IDLE) && req_live;
   assign go_resp  = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd1));

   // With no wait states the access happens on the accepting edge, so it must
   // use the live request rather than the not-yet-captured copy.
   always_comb begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
      acc_rej   = rej_q;
      if (state_q == S_IDLE) begin
         acc_idx   = address[ADDR_BITS+1:2];
         acc_wdata = writedata;
         acc_rd    = memread;
         acc_wr    = memwrite;
         acc_rej   = rej_live;
      end
   end

   // A backdoor load on the same edge lands first, so forward it to the read.
   always_comb begin
      rd_val = mem_q[acc_idx];
      if ((state_q == S_IDLE) && ld_en && (ld_addr == acc_idx)) rd_val = ld_data;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         wdata_q    <= 32'd0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         rej_q      <= 1'b0;
         readdata_q <= 32'd0;
         memready_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         memready_q <= go_resp;
         err_q      <= go_resp && acc_rej;
         if (accept) begin
            idx_q   <= address[ADDR_BITS+1:2];
            wdata_q <= writedata;
            rd_q    <= memread;
            wr_q    <= memwrite;
            rej_q   <= rej_live;
         end
         if (go_resp) begin
            if (acc_rej) begin
               if (acc_rd && !acc_wr) readdata_q <= ERR_DATA;
            end else if (acc_rd) begin
               readdata_q <= rd_val;
            end
         end
      end
   end

   // Array has no reset; a reset edge suppresses both load and committed write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if ((state_q == S_IDLE) && ld_en) mem_q[ld_addr] <= ld_data;
         if (go_resp && acc_wr && !acc_rej) mem_q[acc_idx] <= acc_wdata;
      end
   end

   assign readdata    = readdata_q;
   assign memready    = memready_q;
   assign err         = err_q;
   assign busy        = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: unit 0 runs with two wait states, unit 1 with none.
// Expected {cycle, err, readdata} entries are queued at acceptance and popped on memready.
module tb_mips_mem_responder;

   logic        clk = 1'b0;
   logic        reset     [2];
   logic        memread   [2];
   logic        memwrite  [2];
   logic [31:0] address   [2];
   logic [31:0] writedata [2];
   logic [31:0] readdata  [2];
   logic        memready  [2];
   logic        err       [2];
   logic        busy      [2];
   logic        ld_en     [2];
   logic [7:0]  ld_addr   [2];
   logic [31:0] ld_data   [2];
   logic [1:0]  dbg_state [2];

   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   logic [64:0] exp_q0[$];
   logic [64:0] exp_q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2), .ERR_DATA(32'hDEADBEEF)) u_dut0 (
      .clk(clk), .reset(reset[0]), .memread(memread[0]), .memwrite(memwrite[0]),
      .address(address[0]), .writedata(writedata[0]), .readdata(readdata[0]),
      .memready(memready[0]), .err(err[0]), .busy(busy[0]), .ld_en(ld_en[0]),
      .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .dbg_state_o(dbg_state[0]));

   mips_mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0), .ERR_DATA(32'hDEADBEEF)) u_dut1 (
      .clk(clk), .reset(reset[1]), .memread(memread[1]), .memwrite(memwrite[1]),
      .address(address[1]), .writedata(writedata[1]), .readdata(readdata[1]),
      .memready(memready[1]), .err(err[1]), .busy(busy[1]), .ld_en(ld_en[1]),
      .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .dbg_state_o(dbg_state[1]));

   task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s unit=%0d cyc=%0d actual=%h expected=%h", name, u, cyc, act, expv);
      end
   endtask

   task automatic idle_inputs(input int u);
      memread[u]   = 1'b0;
      memwrite[u]  = 1'b0;
      address[u]   = 32'd0;
      writedata[u] = 32'd0;
      ld_en[u]     = 1'b0;
      ld_addr[u]   = 8'd0;
      ld_data[u]   = 32'd0;
   endtask

   task automatic push_exp(input int u, input int at, input logic e, input logic [31:0] d);
      if (u == 0) exp_q0.push_back({32'(at), e, d});
      else        exp_q1.push_back({32'(at), e, d});
   endtask

   // Monitor: every memready pops one expectation; stray memready/err is a failure.
   always @(negedge clk) begin
      logic [64:0] e;
      for (int u = 0; u < 2; u++) begin
         if (memready[u] === 1'b1) begin
            if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
               total++;
               bad++;
               $display("FAIL unexpected_memready unit=%0d cyc=%0d actual=1 expected=0", u, cyc);
            end else begin
               if (u == 0) e = exp_q0.pop_front();
               else        e = exp_q1.pop_front();
               check("ready_cycle", u, 32'(cyc), e[64:33]);
               check("err", u, {31'd0, err[u]}, {31'd0, e[32]});
               check("readdata", u, readdata[u], e[31:0]);
            end
         end else if (err[u] !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL err_without_ready unit=%0d cyc=%0d actual=%b expected=0", u, cyc, err[u]);
         end
      end
   end

   task automatic load(input int u, input logic [7:0] la, input logic [31:0] d);
      @(negedge clk);
      ld_en[u]   = 1'b1;
      ld_addr[u] = la;
      ld_data[u] = d;
      @(posedge clk);
      #1 idle_inputs(u);
   endtask

   // One access; perturb scribbles request and backdoor inputs while busy.
   task automatic req(input int u, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic ld, input logic [7:0] la,
                      input logic [31:0] ldd, input logic exp_err, input logic [31:0] exp_d,
                      input logic perturb);
      int w;
      w = (u == 0) ? 2 : 0;
      @(negedge clk);
      memread[u]   = rd;
      memwrite[u]  = wr;
      address[u]   = a;
      writedata[u] = wd;
      ld_en[u]     = ld;
      ld_addr[u]   = la;
      ld_data[u]   = ldd;
      @(posedge clk);
      #1;
      push_exp(u, cyc + w, exp_err, exp_d);
      idle_inputs(u);
      for (int k = 0; k <= w; k++) begin
         @(negedge clk);
         check("busy_high", u, {31'd0, busy[u]}, 32'd1);
         if (perturb && k < w) begin
            memread[u]  = 1'b1;
            memwrite[u] = k[0];
            address[u]  = 32'h0000_0400 + 32'(k);
            ld_en[u]    = 1'b1;
            ld_addr[u]  = 8'd2;
            ld_data[u]  = 32'hBAD0_BAD0;
         end else begin
            idle_inputs(u);
         end
      end
      @(negedge clk);
      check("busy_low", u, {31'd0, busy[u]}, 32'd0);
   endtask

   initial begin
      int base;
      for (int u = 0; u < 2; u++) begin
         reset[u] = 1'b1;
         idle_inputs(u);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check("rst_readdata", u, readdata[u], 32'd0);
         check("rst_memready", u, {31'd0, memready[u]}, 32'd0);
         check("rst_err", u, {31'd0, err[u]}, 32'd0);
         check("rst_busy", u, {31'd0, busy[u]}, 32'd0);
         reset[u] = 1'b0;
      end

      // Unit 0: two wait states
      load(0, 8'd5, 32'h1234_5678);
      load(0, 8'd2, 32'h1111_1111);
      req(0, 1, 0, 32'h14, 32'h0, 0, 8'd0, 32'h0, 0, 32'h1234_5678, 1);
      req(0, 0, 1, 32'h20, 32'hCAFE_F00D, 0, 8'd0, 32'h0, 0, 32'h1234_5678, 0);
      req(0, 1, 0, 32'h20, 32'h0, 0, 8'd0, 32'h0, 0, 32'hCAFE_F00D, 0);
      req(0, 1, 0, 32'h22, 32'h0, 0, 8'd0, 32'h0, 1, 32'hDEAD_BEEF, 0);
      req(0, 1, 0, 32'h400, 32'h0, 0, 8'd0, 32'h0, 1, 32'hDEAD_BEEF, 0);
      req(0, 0, 1, 32'h21, 32'h0, 0, 8'd0, 32'h0, 1, 32'hDEAD_BEEF, 0);
      req(0, 1, 0, 32'h20, 32'h0, 0, 8'd0, 32'h0, 0, 32'hCAFE_F00D, 0);
      req(0, 1, 1, 32'h20, 32'h5555_5555, 0, 8'd0, 32'h0, 1, 32'hCAFE_F00D, 0);
      req(0, 1, 0, 32'h8, 32'h0, 0, 8'd0, 32'h0, 0, 32'h1111_1111, 0);

      // Write accepted, then reset during its wait: never committed, no memready
      @(negedge clk);
      memwrite[0]  = 1'b1;
      address[0]   = 32'h8;
      writedata[0] = 32'hFFFF_0000;
      @(posedge clk);
      #1 idle_inputs(0);
      @(negedge clk);
      reset[0] = 1'b1;
      @(posedge clk);
      #1;
      check("abort_readdata", 0, readdata[0], 32'd0);
      check("abort_memready", 0, {31'd0, memready[0]}, 32'd0);
      check("abort_err", 0, {31'd0, err[0]}, 32'd0);
      check("abort_busy", 0, {31'd0, busy[0]}, 32'd0);
      @(negedge clk);
      reset[0] = 1'b0;
      repeat (4) @(negedge clk);
      req(0, 1, 0, 32'h8, 32'h0, 0, 8'd0, 32'h0, 0, 32'h1111_1111, 0);
      req(0, 1, 0, 32'h30, 32'h0, 1, 8'd12, 32'hA5A5_A5A5, 0, 32'hA5A5_A5A5, 0);

      // Unit 1: zero wait states, request held high continuously
      load(1, 8'd3, 32'h3333_3333);
      @(negedge clk);
      memread[1] = 1'b1;
      address[1] = 32'hC;
      base = cyc;
      push_exp(1, base + 1, 0, 32'h3333_3333);
      push_exp(1, base + 3, 0, 32'h3333_3333);
      push_exp(1, base + 5, 0, 32'h3333_3333);
      repeat (6) @(posedge clk);
      #1 idle_inputs(1);
      req(1, 0, 1, 32'h40, 32'h0BAD_F00D, 0, 8'd0, 32'h0, 0, 32'h3333_3333, 0);
      req(1, 1, 0, 32'h40, 32'h0, 0, 8'd0, 32'h0, 0, 32'h0BAD_F00D, 0);
      req(1, 1, 0, 32'h50, 32'h0, 1, 8'd20, 32'h7777_7777, 0, 32'h7777_7777, 0);
      req(1, 0, 1, 32'h54, 32'h0000_0002, 1, 8'd21, 32'h0000_0001, 0, 32'h7777_7777, 0);
      req(1, 1, 0, 32'h54, 32'h0, 0, 8'd0, 32'h0, 0, 32'h0000_0002, 0);
      req(1, 1, 0, 32'h3, 32'h0, 0, 8'd0, 32'h0, 1, 32'hDEAD_BEEF, 0);

      repeat (5) @(negedge clk);
      check("queue_empty", 0, 32'(exp_q0.size()), 32'd0);
      check("queue_empty", 1, 32'(exp_q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Unified instruction/data memory that answers the multicycle MIPS datapath's fetch, load and store requests.
- Sits between the datapath's address/writedata/readdata port and the controller's memread/memwrite strobes.
- Adds programmable wait states and reports completion with a memready pulse, so the controller FSM stalls until each access finishes.
- Provides a backdoor load port for program/data preload by the bench or a boot loader.

Parameters:
ADDR_BITS  8  word-address width; array depth = 2**ADDR_BITS 32-bit words
WAIT_CYCLES  2  extra cycles between request acceptance and memready (0..15)
ERR_DATA  32'hDEADBEEF  value driven on readdata after a rejected read

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
memread  input  1  read request strobe, sampled only in IDLE
memwrite  input  1  write request strobe, sampled only in IDLE
address  input  32  byte address from datapath; word-aligned required
writedata  input  32  store data
readdata  output  32  read result; held until next completed read or reset
memready  output  1  one-cycle pulse: access complete
err  output  1  one-cycle pulse coincident with memready: access rejected
busy  output  1  high whenever state != IDLE
ld_en  input  1  backdoor load enable
ld_addr  input  ADDR_BITS  backdoor word address
ld_data  input  32  backdoor load data

Behaviour:
- One clock; reset is synchronous and active-high, ports named clk and reset.
- Reset values:
  - state = IDLE
  - readdata = 0, memready = 0, err = 0, busy = 0
  - wait counter = 0, captured request cleared
  - Memory array contents are not affected by reset.
- States:
  - IDLE: accept a request.
  - WAIT: count down.
  - RESP: perform the access and drive memready for one cycle, then return to IDLE.
- Acceptance:
  - In IDLE, memread|memwrite high at edge T: capture address, writedata, and the request type (read, write or rejected).
  - Load the counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0, go to RESP; else go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - On the edge where counter==1, go to RESP.
- Latency: memready is high during cycle T+WAIT_CYCLES+1 and low otherwise. Any change to memread/memwrite/address after T is ignored.
- Access at the edge entering RESP:
  - Read: readdata <= array[addr[ADDR_BITS+1:2]].
  - Write: array[...] <= captured writedata; readdata unchanged.
- Rejection: a request is rejected if any of the following holds:
  - addr[1:0] != 0
  - addr[31:ADDR_BITS+2] != 0
  - memread and memwrite both high
- Rejected request:
  - Same latency; no array write.
  - Rejected read drives readdata = ERR_DATA.
  - Rejected write or dual request leaves readdata unchanged.
  - err pulses together with memready.
- Back-to-back: requests are not accepted during WAIT or RESP. The earliest next acceptance is the edge ending the RESP cycle's following IDLE cycle, i.e. 1 idle cycle between accesses.
- Ordering: a read accepted after a completed write to the same address returns the new data.
- Backdoor load:
  - ld_en honoured only in IDLE: array[ld_addr] <= ld_data on that edge.
  - Ignored (dropped, no error) in WAIT/RESP.
  - ld_en and a request together in IDLE: both take effect; the load lands before the request's array access.
- Reset mid-operation:
  - Any pending access is discarded, including a captured write, which is never committed.
  - Outputs return to reset values on that edge; no memready is generated.

Test Plan:
- Preload array[5]=32'h1234_5678 via ld_en; memread with address=32'h14 at T, WAIT_CYCLES=2 -> memready=1 only at T+3, readdata=32'h12345678, err=0, busy high T+1..T+3.
- memwrite with address=32'h20, writedata=32'hCAFEF00D, then memread 32'h20 -> second access returns 32'hCAFEF00D; readdata unchanged (prior value) after the write's memready.
- memread with address=32'h22 (misaligned) and separately address=32'h400 (out of range, ADDR_BITS=8) -> memready and err pulse together at T+3, readdata=32'hDEADBEEF, array unchanged.
- memwrite to 32'h8 accepted, reset asserted at T+1 -> no memready, outputs zero, later read of 32'h8 returns the old preloaded value.
- Requests held high continuously with WAIT_CYCLES=0 -> memready every other... accepted at T, ready T+1, next accepted T+2, ready T+3; memread toggled/address changed during WAIT has no effect.
- ld_en asserted while busy -> load ignored; ld_en and memread to the same word together in IDLE -> read returns ld_data.
